// File: rtl/exc_pkg.sv
// exc_pkg: shared state encoding, cause width and handler default for the exception controller
package exc_pkg;
  localparam int CAUSE_W = 4;
  localparam logic [31:0] HANDLER_ADDR_DEF = 32'h8000_0000;
  typedef enum logic {USER = 1'b0, KERNEL = 1'b1} exc_state_e;
endpackage

// File: rtl/exc_prio_enc.sv
// exc_prio_enc: lowest-index-wins priority encoder over the request vector
module exc_prio_enc
  import exc_pkg::*;
#(
  parameter int NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] req,
  output logic               valid,
  output logic [CAUSE_W-1:0] idx
);
  // scan from the top down so the lowest set bit is the last one written
  always_comb begin
    valid = |req;
    idx = '0;
    for (int i = NUM_IRQ - 1; i >= 0; i--) if (req[i]) idx = CAUSE_W'(i);
  end
endmodule

// File: rtl/exc_ctrl.sv
// exc_ctrl: edge-detected interrupt controller with PC redirect; EXC_TIMER_EN adds a periodic tick on channel 0
module exc_ctrl
  import exc_pkg::*;
#(
  parameter int NUM_IRQ = 4,
  parameter int PC_W = 32,
  parameter logic [PC_W-1:0] HANDLER_ADDR = PC_W'(HANDLER_ADDR_DEF)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_IRQ-1:0] irq_in,
  input  logic               mask_wr,
  input  logic [NUM_IRQ-1:0] mask_wdata,
  input  logic [PC_W-1:0]    if_pc,
  input  logic [PC_W-1:0]    if_pc_next,
  input  logic               if_is_jump,
  input  logic               eret,
  input  logic               tmr_wr,
  input  logic [31:0]        tmr_wdata,
  output logic               redir,
  output logic [PC_W-1:0]    redir_pc,
  output logic               flush_id,
  output logic [PC_W-1:0]    epc,
  output logic [CAUSE_W-1:0] cause,
  output logic               kernel
);
  exc_state_e state, state_nxt;
  logic [NUM_IRQ-1:0] irq_q, pending, mask, edges, clr;
  logic [CAUSE_W-1:0] sel;
  logic valid, take, do_ret, ret_q;

`ifdef EXC_TIMER_EN
  logic [31:0] tmr_cnt, tmr_per;
  logic tick;
  assign tick = (tmr_per != 32'd0) && (tmr_cnt == tmr_per - 32'd1);
  // free-running period counter; a write restarts it from zero
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tmr_cnt <= '0;
      tmr_per <= '0;
    end else if (tmr_wr) begin
      tmr_per <= tmr_wdata;
      tmr_cnt <= '0;
    end else if (tmr_per != 32'd0) tmr_cnt <= tick ? 32'd0 : tmr_cnt + 32'd1;
  assign edges = (irq_in & ~irq_q) | NUM_IRQ'(tick);
`else
  logic unused_tmr;
  assign unused_tmr = ^{tmr_wr, tmr_wdata};
  assign edges = irq_in & ~irq_q;
`endif

  exc_prio_enc #(.NUM_IRQ(NUM_IRQ)) u_prio (
    .req  (pending & ~mask),
    .valid(valid),
    .idx  (sel)
  );

  // the cycle right after a return is forced to stay in USER so the interrupted code advances
  always_comb begin
    take = (state == USER) && !ret_q && valid;
    do_ret = (state == KERNEL) && eret;
    clr = take ? NUM_IRQ'(1) << sel : '0;
    state_nxt = take ? KERNEL : do_ret ? USER : state;
    redir = take || do_ret;
    redir_pc = take ? HANDLER_ADDR : epc;
    flush_id = take && if_is_jump;
    kernel = (state == KERNEL);
  end

  // state, edge capture, pending (new edge beats clear), mask and saved context
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= USER;
      irq_q <= '0;
      pending <= '0;
      mask <= '0;
      ret_q <= 1'b0;
      epc <= '0;
      cause <= '0;
    end else begin
      state <= state_nxt;
      irq_q <= irq_in;
      pending <= (pending & ~clr) | edges;
      ret_q <= do_ret;
      if (mask_wr) mask <= mask_wdata;
      if (take) begin
        epc <= if_is_jump ? if_pc : if_pc_next;
        cause <= sel;
      end
    end
endmodule

// File: tb/tb_exc_ctrl.sv
// tb_exc_ctrl: directed scenarios plus random traffic against a behavioural model of exc_ctrl
module tb_exc_ctrl;
  localparam logic [31:0] H = 32'h8000_0000;
  logic clk = 0, reset = 1;
  logic [3:0] irq_in = 0, mask_wdata = 0, cause;
  logic mask_wr = 0, if_is_jump = 0, eret = 0, tmr_wr = 0;
  logic [31:0] if_pc = 0, if_pc_next = 0, tmr_wdata = 0, redir_pc, epc;
  logic redir, flush_id, kernel;
  int checks = 0, errors = 0;

  bit [3:0] m_pend, m_mask, m_prev;
  bit m_kern, m_block;
  bit [31:0] m_epc, m_per, m_cnt;
  int m_cause;

  exc_ctrl dut (
    .clk(clk), .reset(reset), .irq_in(irq_in), .mask_wr(mask_wr), .mask_wdata(mask_wdata),
    .if_pc(if_pc), .if_pc_next(if_pc_next), .if_is_jump(if_is_jump), .eret(eret),
    .tmr_wr(tmr_wr), .tmr_wdata(tmr_wdata), .redir(redir), .redir_pc(redir_pc),
    .flush_id(flush_id), .epc(epc), .cause(cause), .kernel(kernel)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int m_sel();
    for (int i = 0; i < 4; i++) if (m_pend[i] && !m_mask[i]) return i;
    return -1;
  endfunction

  function automatic bit m_take();
    return !m_kern && !m_block && m_sel() >= 0;
  endfunction

  task automatic m_reset();
    m_pend = 0; m_mask = 0; m_prev = 0; m_kern = 0; m_block = 0;
    m_epc = 0; m_cause = 0; m_per = 0; m_cnt = 0;
  endtask

  task automatic drive(input logic [3:0] irq, input logic er = 0, input logic [31:0] pc = 0,
                       input logic jmp = 0, input logic mwr = 0, input logic [3:0] md = 0,
                       input logic twr = 0, input logic [31:0] twd = 0);
    bit t, r;
    @(negedge clk);
    irq_in = irq; eret = er; if_pc = pc; if_pc_next = pc + 4; if_is_jump = jmp;
    mask_wr = mwr; mask_wdata = md; tmr_wr = twr; tmr_wdata = twd;
    #1;
    t = m_take();
    r = t || (m_kern && er);
    check("redir", redir, r);
    if (r) check("redir_pc", redir_pc, t ? H : m_epc);
    check("flush_id", flush_id, t && jmp);
    check("kernel", kernel, m_kern);
    check("epc", epc, m_epc);
    check("cause", cause, m_cause);
  endtask

  task automatic adv();
    int s;
    bit t, tk;
    bit [3:0] ne;
    @(posedge clk);
    s = m_sel();
    t = m_take();
    tk = 0;
`ifdef EXC_TIMER_EN
    tk = m_per != 0 && m_cnt == m_per - 1;
    if (tmr_wr) begin m_per = tmr_wdata; m_cnt = 0; end
    else if (m_per != 0) m_cnt = tk ? 0 : m_cnt + 1;
`endif
    ne = irq_in & ~m_prev;
    ne[0] = ne[0] | tk;
    m_block = m_kern && eret;
    if (t) begin
      m_pend[s] = 0; m_cause = s; m_kern = 1;
      m_epc = if_is_jump ? if_pc : if_pc_next;
    end else if (m_kern && eret) m_kern = 0;
    m_pend = m_pend | ne;
    m_prev = irq_in;
    if (mask_wr) m_mask = mask_wdata;
  endtask

  task automatic step(input logic [3:0] irq, input logic er = 0, input logic [31:0] pc = 0,
                      input logic jmp = 0, input logic mwr = 0, input logic [3:0] md = 0);
    drive(irq, er, pc, jmp, mwr, md);
    adv();
  endtask

  initial begin
    logic [3:0] irq;
    m_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); reset = 0;
    #1;
    check("rst_redir", redir, 0); check("rst_flush", flush_id, 0);
    check("rst_kernel", kernel, 0); check("rst_epc", epc, 0); check("rst_cause", cause, 0);

    // channel 2, not a jump
    step(4'b0100);
    drive(4'b0100, 0, 32'h100);
    check("s1_redir", redir, 1); check("s1_pc", redir_pc, H); check("s1_flush", flush_id, 0);
    adv();
    drive(4'b0100);
    check("s1_epc", epc, 32'h104); check("s1_cause", cause, 2); check("s1_kernel", kernel, 1);
    adv();
    drive(4'b0000, 1);
    check("s1_eret", redir, 1); check("s1_eret_pc", redir_pc, 32'h104);
    adv();
    step(4'b0000);
    // channel 2 on a jump
    step(4'b0100);
    drive(4'b0100, 0, 32'h100, 1);
    check("s2_flush", flush_id, 1);
    adv();
    drive(4'b0100);
    check("s2_epc", epc, 32'h100);
    adv();
    step(4'b0000, 1);
    step(4'b0000);
    // channels 1 and 3 together
    step(4'b1010);
    step(4'b1010, 0, 32'h200);
    drive(4'b1010);
    check("s3_cause1", cause, 1);
    adv();
    step(4'b1010, 1);
    drive(4'b1010);
    check("s3_hold", redir, 0);
    adv();
    drive(4'b1010, 0, 32'h300);
    check("s3_take", redir, 1);
    adv();
    drive(4'b0000);
    check("s3_cause3", cause, 3);
    adv();
    step(4'b0000, 1);
    step(4'b0000);
    // masking channel 0
    step(4'b0000, 0, 0, 0, 1, 4'b0001);
    step(4'b0001);
    drive(4'b0001);
    check("s4_masked", redir, 0);
    adv();
    drive(4'b0001, 0, 0, 0, 1, 4'b0000);
    check("s4_wr_pending", redir, 0);
    adv();
    drive(4'b0001);
    check("s4_take", redir, 1);
    adv();
    drive(4'b0000);
    check("s4_cause", cause, 0); check("s4_kernel", kernel, 1);
    adv();
    step(4'b0000, 1);
    step(4'b0000);

`ifdef EXC_TIMER_EN
    drive(4'b0000, 0, 0, 0, 0, 0, 1, 5);
    adv();
    for (int i = 0; i < 40; i++) begin
      drive(4'b0000, m_kern && ($urandom % 2 == 0), 32'h400 + 4 * i);
      adv();
    end
    drive(4'b0000, m_kern, 0, 0, 0, 0, 1, 0);
    adv();
    step(4'b0000, m_kern);
    step(4'b0000, m_kern);
    for (int i = 0; i < 12; i++) begin
      drive(4'b0000);
      check("tmr_off", redir, 0);
      adv();
    end
`endif

    // random traffic
    irq = 0;
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < 4; b++) if ($urandom % 8 == 0) irq[b] = ~irq[b];
      drive(irq, m_kern ? ($urandom % 4 == 0) : ($urandom % 8 == 0), $urandom & 32'hffff_fffc,
            $urandom % 2, $urandom % 16 == 0, 4'($urandom & $urandom),
            $urandom % 64 == 0, $urandom % 8);
      adv();
    end

    // reset while in the handler with a request pending
    step(4'b0000, m_kern, 0, 0, 1, 4'b0000);
    step(4'b0000, m_kern);
    step(4'b0000);
    step(4'b0100);
    step(4'b0100, 0, 32'h500);
    step(4'b0010);
    @(negedge clk);
    irq_in = 0; eret = 0; mask_wr = 0; tmr_wr = 0;
    #1;
    check("pre_rst_kernel", kernel, 1);
    reset = 1;
    #1;
    check("rst2_kernel", kernel, 0); check("rst2_epc", epc, 0);
    check("rst2_cause", cause, 0); check("rst2_redir", redir, 0);
    @(posedge clk);
    @(negedge clk); reset = 0;
    m_reset();
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000);
      check("rst2_pending", redir, 0);
      adv();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
